serv_immdec_wide: RTL
=====================

Name: serv_immdec_wide

Overview:
Parametrised bit-serial immediate decoder for the SERV datapath, generalised from 1-bit to W-bit serial width.
- Captures the instruction word from the fetch bus and holds rd/rs1/rs2 addresses.
- On request, assembles the immediate for an explicitly selected format (I/S/B/U/J/CSR-zimm) and streams it LSB-first, W bits per beat, over 32/W beats with stall support.
- Sits between instruction fetch (wishbone read data) and the serial ALU/CSR datapath.

Parameters:
W, 1, serial datapath width in bits; legal values 1, 2, 4, 8, 16, 32.
CSR_EN, 1, 1 enables CSR zimm format (fmt=5); 0 makes fmt=5 decode as invalid.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_wb_en  in  1  instruction capture strobe
i_wb_rdt  in  25 [31:7]  instruction word bits 31..7
i_fmt  in  3  format: 0=I 1=S 2=B 3=U 4=J 5=CSR zimm, 6/7 invalid; sampled with i_start
i_start  in  1  begin streaming the immediate
i_cnt_en  in  1  advance one beat
o_rd_addr  out  5  instr[11:7]
o_rs1_addr  out  5  instr[19:15]
o_rs2_addr  out  5  instr[24:20]
o_imm  out  W  current immediate beat
o_imm_valid  out  1  o_imm holds a valid beat
o_last  out  1  current beat is the final one
o_busy  out  1  streaming in progress; i_wb_en ignored

Behaviour:
- States: IDLE (no instruction held), LOADED (instruction held), SHIFT (streaming).
- Reset (async, any state): state=IDLE; all outputs, the instruction register, the immediate shift register and the beat counter are 0. Release is synchronous to the next i_clk edge.
- Capture: i_wb_en in IDLE or LOADED latches i_wb_rdt; next cycle state=LOADED and the address outputs update. i_wb_en in SHIFT is ignored, with no corruption of state.
- Start: i_start in LOADED (with i_wb_en low) builds the 32-bit immediate from the held instruction and sets the counter to 0. Next cycle state=SHIFT, o_imm_valid=1, o_imm=imm[W-1:0].
  - i_start in IDLE or SHIFT is ignored.
  - i_wb_en and i_start together in LOADED: capture wins; start is dropped.
- Immediate assembly (sign bit = instr[31]):
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: {instr[31:12], 12'b0}
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - CSR: zero-extended instr[19:15]
  - Invalid (or fmt=5 with CSR_EN=0): 32'b0
- Streaming: counter is log2(32/W) bits, minimum 1.
  - In SHIFT, i_cnt_en=1 shifts the register right by W and increments the counter.
  - i_cnt_en=0 holds o_imm and the counter (stall); o_imm_valid stays 1.
  - o_imm = beat k = imm[(k+1)W-1 : kW]; o_last = (counter == 32/W-1).
  - i_cnt_en on the last beat: next state=LOADED, o_imm_valid=0, o_last=0, o_imm=0. The instruction is retained, so a new i_start reissues the immediate, possibly in another format.
  - W=32: a single beat, with o_last=1 on that beat.
- Address outputs are stable from capture until the next capture or reset, independent of streaming.
- o_busy = (state==SHIFT).
- Reset asserted mid-stream: outputs go to 0 immediately (asynchronous). No partial beat is required after release.

Test Plan:
- W=4: capture 0xFFF10093 (addi x1,x2,-1), fmt=0, start, i_cnt_en=1 continuously -> 8 beats of 0xF, o_last on beat 7; rd=1, rs1=2; then LOADED with o_imm_valid=0.
- W=1: capture 0x00512423 (sw x5,8(x2)), fmt=1 -> serial stream reconstructs 0x00000008; rs1=2, rs2=5. Insert 3-cycle i_cnt_en=0 stalls mid-stream -> stream unchanged.
- W=8: capture 0xFE000EE3, fmt=2 -> beats 0xFC,0xFF,0xFF,0xFF (0xFFFFFFFC). Then reissue the same word with fmt=3 -> 0xFE000000.
- W=2: capture 0x0010006F, fmt=4 -> 0x00000800. Capture 0x123450B7, fmt=3 -> 0x12345000.
- W=4, CSR_EN=1: capture 0x300FD073, fmt=5 -> 0x0000001F. With CSR_EN=0, or fmt=7 -> all-zero beats.
- Edge cases:
  - i_wb_en pulsed during SHIFT -> ignored; o_busy=1; stream intact.
  - i_wb_en+i_start together in LOADED -> new capture, no stream.
  - Assert i_rst at beat 3 -> all outputs 0 the same cycle; state IDLE; i_start then ignored until a capture.

Source files
------------

// File: rtl/serv_immdec_wide.sv
// Bit-serial immediate decoder for SERV, W bits per beat.
// Holds the fetched instruction and streams a selected immediate format LSB-first.
module serv_immdec_wide #(
  parameter int unsigned W      = 1,
  parameter bit          CSR_EN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_en,
  input  logic [31:7]   i_wb_rdt,
  input  logic [2:0]    i_fmt,
  input  logic          i_start,
  input  logic          i_cnt_en,
  output logic [4:0]    o_rd_addr,
  output logic [4:0]    o_rs1_addr,
  output logic [4:0]    o_rs2_addr,
  output logic [W-1:0]  o_imm,
  output logic          o_imm_valid,
  output logic          o_last,
  output logic          o_busy
);

  localparam int unsigned Beats = 32 / W;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StLoaded, StShift} state_e;

  state_e          state_q;
  logic [31:7]     instr_q;
  logic [31:0]     imm_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     imm_new;
  logic            sgn;

  assign sgn = instr_q[31];

  always_comb begin
    imm_new = '0;
    case (i_fmt)
      3'd0: imm_new = {{20{sgn}}, instr_q[31:20]};
      3'd1: imm_new = {{20{sgn}}, instr_q[31:25], instr_q[11:7]};
      3'd2: imm_new = {{19{sgn}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
      3'd3: imm_new = {instr_q[31:12], 12'b0};
      3'd4: imm_new = {{11{sgn}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21],
                       1'b0};
      3'd5: imm_new = CSR_EN ? {27'b0, instr_q[19:15]} : 32'b0;
      default: imm_new = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      instr_q <= '0;
      imm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StLoaded: begin
          // Capture takes priority over a simultaneous start.
          if (i_wb_en) begin
            instr_q <= i_wb_rdt;
            state_q <= StLoaded;
          end else if (state_q == StLoaded && i_start) begin
            imm_q   <= imm_new;
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (i_cnt_en) begin
            if (cnt_q == LastCnt) begin
              imm_q   <= '0;
              cnt_q   <= '0;
              state_q <= StLoaded;
            end else begin
              imm_q <= imm_q >> W;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_rd_addr   = instr_q[11:7];
  assign o_rs1_addr  = instr_q[19:15];
  assign o_rs2_addr  = instr_q[24:20];
  assign o_busy      = (state_q == StShift);
  assign o_imm_valid = o_busy;
  assign o_last      = o_busy && (cnt_q == LastCnt);
  assign o_imm       = o_busy ? imm_q[W-1:0] : '0;

endmodule
